dcf77_frame_tx: RTL and testbench
=================================

DCF77_FRAME_TX -- requirements
Module: dcf77_frame_tx

Interface
REQ-001 Parameter PULSE0_MS, default 100, meaning: dcf_out high time in ms_tick periods for a '0' bit.
REQ-002 Parameter PULSE1_MS, default 200, meaning: dcf_out high time in ms_tick periods for a '1' bit.
REQ-003 Parameter SEC_MS, default 1000, meaning: ms_tick periods per second slot.
REQ-004 qzt_clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 GSR  input  1  reset, synchronous and active-high.
REQ-006 ms_tick  input  1  one-cycle strobe, once per millisecond.
REQ-007 start  input  1  request to transmit one minute frame using the current field inputs.
REQ-008 minute  input  7  BCD minute, LSB first on air.
REQ-009 hour  input  6  BCD hour.
REQ-010 day  input  6  BCD day of month.
REQ-011 wday  input  3  day of week, 1-7.
REQ-012 month  input  5  BCD month.
REQ-013 year  input  8  BCD year within century.
REQ-014 flags  input  5  status bits placed in frame bits 15-19, flags[0] in bit 15.
REQ-015 dcf_out  output  1  amplitude-reduction envelope; 1 means carrier reduced.
REQ-016 busy  output  1  frame transmission in progress.
REQ-017 sec_cnt  output  6  current second slot, 0-59.
REQ-018 frame  output  59  latched frame; bit n is transmitted in second n.
REQ-019 frame_done  output  1  one-cycle pulse at the end of second 59.

Function
REQ-020 Two states SHALL be used: IDLE and SEND.
REQ-021 In IDLE, start=1 SHALL latch all field inputs into frame, clear ms_cnt and sec_cnt to 0, and enter SEND on the next edge. An ms_tick in the same cycle SHALL be ignored.
REQ-022 Frame layout SHALL be:
- bit 0 = 0
- bits 1-14 = 0
- bits 15-19 = flags
- bit 20 = 1
- bits 21-27 = minute
- bit 28 = P1
- bits 29-34 = hour
- bit 35 = P2
- bits 36-41 = day
- bits 42-44 = wday
- bits 45-49 = month
- bits 50-57 = year
- bit 58 = P3
REQ-023 Each field SHALL be placed LSB at the lowest frame index.
REQ-024 Parity bits SHALL be even parity:
- P1 = XOR of bits 21-27
- P2 = XOR of bits 29-34
- P3 = XOR of bits 36-57
REQ-025 The whole frame SHALL have an even number of ones across bits 21-58.
REQ-026 Field values SHALL be transmitted unchecked; non-BCD input is not corrected.
REQ-027 In SEND, each ms_tick SHALL increment the internal 10-bit ms_cnt. At ms_cnt = SEC_MS-1 with ms_tick, ms_cnt SHALL wrap to 0 and sec_cnt SHALL increment.
REQ-028 dcf_out SHALL be decoded from registered state only, with no combinational path from inputs.
REQ-029 dcf_out = 1 iff busy, sec_cnt <= 58, and ms_cnt < (frame[sec_cnt] ? PULSE1_MS : PULSE0_MS).
REQ-030 In second 59, dcf_out SHALL stay 0 for the whole slot (minute marker).
REQ-031 At the wrap out of second 59, frame_done SHALL pulse for one cycle.
- If start=1 in that cycle: fields are relatched and sec_cnt = 0 with SEND kept, so there is no gap.
- Otherwise: return to IDLE with sec_cnt = 0.
REQ-032 start while busy, other than in the REQ-031 cycle, SHALL be ignored; frame SHALL stay unchanged during SEND.
REQ-033 Field inputs SHALL be sampled only in the latch cycle; later changes SHALL have no effect on the current frame.
REQ-034 busy SHALL equal (state == SEND).

Reset
REQ-035 GSR=1 at a clock edge SHALL force IDLE with dcf_out=0, busy=0, sec_cnt=0, ms_cnt=0, frame=0 and frame_done=0, regardless of other inputs.
REQ-036 GSR asserted mid-frame SHALL abort transmission immediately; a pulse in progress ends on the following cycle.
REQ-037 start in the cycle GSR deasserts SHALL be honoured on the next edge only if GSR=0 at that edge.

Verification
REQ-038 Latch and parity: minute=7'h37, hour=6'h12, day=6'h25, wday=3, month=5'h11, year=8'h24, flags=0, start pulse -> frame[28]=1, frame[35]=0, frame[58]=1, frame[20]=1, frame[14:0]=0.
REQ-039 Pulse widths: with the REQ-038 frame, count high ms_ticks per slot -> second 0 gives 100, second 20 gives 200, second 21 (minute bit0=1) gives 200, second 59 gives 0.
REQ-040 Back-to-back frames: start held at the second-59 wrap with minute changed to 7'h38 -> frame_done for 1 cycle, busy stays 1, new frame[21:27] = 0001110b LSB-first, no missing second.
REQ-041 Mid-frame: start pulsed at sec_cnt=30 -> frame unchanged; GSR at sec_cnt=40, ms_cnt=50 -> next cycle busy=0, dcf_out=0, sec_cnt=0.
REQ-042 Boundary: ms_tick coincident with start in IDLE -> first SEND ms_cnt=0; dcf_out high for exactly 100 subsequent ticks.
REQ-043 Loopback: feed the bits decoded from dcf_out into the team's parity checker with a 59-bit buffer -> sincro_out=1 for 5 random field sets; flipping one data bit -> sincro_out=0.

Source files
------------

// File: rtl/dcf77_frame_tx.sv
// DCF77 minute-frame transmitter: latches the time fields into a 59-bit frame and keys the carrier-reduction envelope.
// Latency: the frame latches on the edge after start; dcf_out is registered and tracks sec_cnt/ms_cnt with no extra delay.
// Backpressure: start is accepted in IDLE, or at the second-59 wrap for gapless frames; at any other time it is ignored.
module dcf77_frame_tx #(
    parameter int PULSE0_MS = 100,
    parameter int PULSE1_MS = 200,
    parameter int SEC_MS    = 1000
) (
    input  logic        qzt_clk,
    input  logic        GSR,
    input  logic        ms_tick,
    input  logic        start,
    input  logic [6:0]  minute,
    input  logic [5:0]  hour,
    input  logic [5:0]  day,
    input  logic [2:0]  wday,
    input  logic [4:0]  month,
    input  logic [7:0]  year,
    input  logic [4:0]  flags,
    output logic        dcf_out,
    output logic        busy,
    output logic [5:0]  sec_cnt,
    output logic [58:0] frame,
    output logic        frame_done
);

    localparam logic [9:0] MS_LAST = 10'(SEC_MS - 1);
    localparam logic [9:0] PW0     = 10'(PULSE0_MS);
    localparam logic [9:0] PW1     = 10'(PULSE1_MS);

    typedef enum logic {IDLE, SEND} state_t;

    state_t      state_q, state_d;
    logic [9:0]  ms_cnt_q, ms_cnt_d;
    logic [5:0]  sec_cnt_q, sec_cnt_d;
    logic [58:0] frame_q, frame_d, frame_new;
    logic        done_q, done_d;
    logic        dcf_q, dcf_d;
    logic        cur_bit;
    logic [9:0]  width;

    // Each parity bit makes its own group even, so bits 21-58 are even as a whole.
    always_comb begin
        frame_new = {^{day, wday, month, year}, year, month, wday, day,
                     ^hour, hour, ^minute, minute, 1'b1, flags, 15'd0};
    end

    always_comb begin
        state_d   = state_q;
        ms_cnt_d  = ms_cnt_q;
        sec_cnt_d = sec_cnt_q;
        frame_d   = frame_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    frame_d   = frame_new;
                    ms_cnt_d  = '0;
                    sec_cnt_d = '0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (ms_tick) begin
                    if (ms_cnt_q == MS_LAST) begin
                        ms_cnt_d = '0;
                        if (sec_cnt_q == 6'd59) begin
                            done_d    = 1'b1;
                            sec_cnt_d = '0;
                            if (start) begin
                                frame_d = frame_new;
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
                            sec_cnt_d = sec_cnt_q + 6'd1;
                        end
                    end else begin
                        ms_cnt_d = ms_cnt_q + 10'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Envelope is decoded from next-state values so the register matches the current slot exactly.
        cur_bit = (sec_cnt_d <= 6'd58) ? frame_d[sec_cnt_d] : 1'b0;
        width   = cur_bit ? PW1 : PW0;
        dcf_d   = (state_d == SEND) && (sec_cnt_d <= 6'd58) && (ms_cnt_d < width);
    end

    always_ff @(posedge qzt_clk) begin
        if (GSR) begin
            state_q   <= IDLE;
            ms_cnt_q  <= '0;
            sec_cnt_q <= '0;
            frame_q   <= '0;
            done_q    <= 1'b0;
            dcf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ms_cnt_q  <= ms_cnt_d;
            sec_cnt_q <= sec_cnt_d;
            frame_q   <= frame_d;
            done_q    <= done_d;
            dcf_q     <= dcf_d;
        end
    end

    assign dcf_out    = dcf_q;
    assign busy       = (state_q == SEND);
    assign sec_cnt    = sec_cnt_q;
    assign frame      = frame_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_dcf77_frame_tx.sv
// Bench for dcf77_frame_tx with shortened slot timing; a monitor decodes dcf_out per slot and scores it against queued frames.
module tb_dcf77_frame_tx;

    localparam int P0 = 6;
    localparam int P1 = 13;
    localparam int SM = 32;

    logic        qzt_clk = 1'b0;
    logic        GSR = 1'b1;
    logic        ms_tick = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  minute = '0;
    logic [5:0]  hour = '0;
    logic [5:0]  day = '0;
    logic [2:0]  wday = '0;
    logic [4:0]  month = '0;
    logic [7:0]  year = '0;
    logic [4:0]  flags = '0;
    logic        dcf_out;
    logic        busy;
    logic [5:0]  sec_cnt;
    logic [58:0] frame;
    logic        frame_done;

    dcf77_frame_tx #(.PULSE0_MS(P0), .PULSE1_MS(P1), .SEC_MS(SM)) dut (
        .qzt_clk(qzt_clk), .GSR(GSR), .ms_tick(ms_tick), .start(start),
        .minute(minute), .hour(hour), .day(day), .wday(wday), .month(month),
        .year(year), .flags(flags), .dcf_out(dcf_out), .busy(busy),
        .sec_cnt(sec_cnt), .frame(frame), .frame_done(frame_done)
    );

    always #5 qzt_clk = ~qzt_clk;

    int tests = 0;
    int fails = 0;
    logic [58:0] exp_q[$];

    int hi[60];
    int tk[60];
    logic [58:0] seen;
    logic seen_ok;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference frame built bit by bit from the field table, parity by counting ones.
    function automatic logic [58:0] ref_frame(input logic [6:0] mi, input logic [5:0] hr,
                                              input logic [5:0] dy, input logic [2:0] wd,
                                              input logic [4:0] mo, input logic [7:0] yr,
                                              input logic [4:0] fl);
        logic [58:0] f;
        int ones;
        f = '0;
        for (int i = 0; i < 5; i++) f[15+i] = fl[i];
        f[20] = 1'b1;
        for (int i = 0; i < 7; i++) f[21+i] = mi[i];
        for (int i = 0; i < 6; i++) f[29+i] = hr[i];
        for (int i = 0; i < 6; i++) f[36+i] = dy[i];
        for (int i = 0; i < 3; i++) f[42+i] = wd[i];
        for (int i = 0; i < 5; i++) f[45+i] = mo[i];
        for (int i = 0; i < 8; i++) f[50+i] = yr[i];
        ones = 0;
        for (int i = 21; i <= 27; i++) ones += int'(f[i]);
        f[28] = (ones % 2) == 1;
        ones = 0;
        for (int i = 29; i <= 34; i++) ones += int'(f[i]);
        f[35] = (ones % 2) == 1;
        ones = 0;
        for (int i = 36; i <= 57; i++) ones += int'(f[i]);
        f[58] = (ones % 2) == 1;
        return f;
    endfunction

    // Receiver-side check of a decoded 59-bit buffer.
    function automatic logic sincro(input logic [58:0] b);
        int ones;
        ones = 0;
        for (int i = 21; i <= 28; i++) ones += int'(b[i]);
        if ((ones % 2) != 0) return 1'b0;
        ones = 0;
        for (int i = 29; i <= 35; i++) ones += int'(b[i]);
        if ((ones % 2) != 0) return 1'b0;
        ones = 0;
        for (int i = 36; i <= 58; i++) ones += int'(b[i]);
        if ((ones % 2) != 0) return 1'b0;
        return (b[0] == 1'b0) && (b[20] == 1'b1);
    endfunction

    task automatic clear_acc();
        for (int s = 0; s < 60; s++) begin
            hi[s] = 0;
            tk[s] = 0;
        end
        seen_ok = 1'b0;
        seen = '0;
    endtask

    task automatic eval_frame();
        logic [58:0] exp;
        logic [58:0] dec;
        int bad;
        int badtk;
        int k;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_frame: got frame_done expected none");
            clear_acc();
            return;
        end
        exp = exp_q.pop_front();
        dec = '0;
        bad = 0;
        badtk = 0;
        for (int s = 0; s < 59; s++) begin
            dec[s] = (hi[s] == P1);
            if (hi[s] != P0 && hi[s] != P1) bad++;
        end
        if (hi[59] != 0) bad++;
        for (int s = 0; s < 60; s++) if (tk[s] != SM) badtk++;
        check("dcf_bits", 64'(dec), 64'(exp));
        check("pulse_widths", 64'(bad), 64'(0));
        check("slot_ticks", 64'(badtk), 64'(0));
        check("frame_reg", 64'(seen), 64'(exp));
        check("busy_at_done", 64'(busy), 64'(exp_q.size() > 0));
        check("sincro", 64'(sincro(dec)), 64'(1));
        k = $urandom_range(21, 57);
        dec[k] = ~dec[k];
        check("sincro_flip", 64'(sincro(dec)), 64'(0));
        clear_acc();
    endtask

    initial begin
        clear_acc();
        forever begin
            @(negedge qzt_clk);
            if (GSR) begin
                clear_acc();
                continue;
            end
            if (frame_done) eval_frame();
            if (busy && ms_tick && sec_cnt < 6'd60) begin
                tk[sec_cnt]++;
                hi[sec_cnt] += int'(dcf_out);
            end
            if (busy && sec_cnt == 6'd58 && !seen_ok) begin
                seen = frame;
                seen_ok = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge qzt_clk);
        #1;
        ms_tick = ($urandom_range(0, 3) != 0);
    endtask

    task automatic set_rand_fields();
        minute = 7'($urandom);
        hour   = 6'($urandom);
        day    = 6'($urandom);
        wday   = 3'($urandom);
        month  = 5'($urandom);
        year   = 8'($urandom);
        flags  = 5'($urandom);
    endtask

    task automatic push_exp();
        exp_q.push_back(ref_frame(minute, hour, day, wday, month, year, flags));
    endtask

    task automatic issue_start();
        start = 1'b1;
        push_exp();
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 4000 && busy; i++) step();
        check("wait_idle", 64'(busy), 64'(0));
        step();
    endtask

    task automatic wait_sec(input int n);
        for (int i = 0; i < 4000 && sec_cnt != 6'(n); i++) step();
        check($sformatf("reach_sec%0d", n), 64'(sec_cnt), 64'(n));
    endtask

    task automatic wait_done();
        for (int i = 0; i < 4000 && !frame_done; i++) step();
        check("wait_done", 64'(frame_done), 64'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset dominates a simultaneous start
        GSR = 1'b1;
        start = 1'b1;
        set_rand_fields();
        repeat (3) step();
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_dcf", 64'(dcf_out), 64'(0));
        check("rst_sec", 64'(sec_cnt), 64'(0));
        check("rst_frame", 64'(frame), 64'(0));
        check("rst_done", 64'(frame_done), 64'(0));

        // Release reset with start and a coincident ms_tick
        GSR = 1'b0;
        start = 1'b1;
        minute = 7'h37; hour = 6'h12; day = 6'h25; wday = 3'd3;
        month = 5'h11; year = 8'h24; flags = 5'd0;
        push_exp();
        ms_tick = 1'b1;
        step();
        start = 1'b0;
        check("start_busy", 64'(busy), 64'(1));
        check("start_sec", 64'(sec_cnt), 64'(0));
        check("p1_bit28", 64'(frame[28]), 64'(1));
        check("p2_bit35", 64'(frame[35]), 64'(0));
        check("p3_bit58", 64'(frame[58]), 64'(1));
        check("bit20", 64'(frame[20]), 64'(1));
        check("bits14_0", 64'(frame[14:0]), 64'(0));

        // Start and new fields mid-frame must not disturb the latched frame
        wait_sec(30);
        set_rand_fields();
        start = 1'b1;
        step();
        start = 1'b0;

        // Gapless relatch at the second-59 wrap
        wait_sec(59);
        minute = 7'h38;
        start = 1'b1;
        push_exp();
        wait_done();
        check("b2b_busy", 64'(busy), 64'(1));
        check("b2b_minute", 64'(frame[27:21]), 64'(7'h38));
        check("b2b_sec", 64'(sec_cnt), 64'(0));
        start = 1'b0;
        wait_idle();

        for (int n = 0; n < 5; n++) begin
            set_rand_fields();
            issue_start();
            repeat ($urandom_range(1, 20)) step();
            set_rand_fields();
            wait_idle();
        end

        // Abort while a pulse is on air
        set_rand_fields();
        issue_start();
        wait_sec(40);
        for (int i = 0; i < 200 && !dcf_out; i++) step();
        check("abort_pulse_seen", 64'(dcf_out), 64'(1));
        GSR = 1'b1;
        exp_q.delete();
        step();
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_dcf", 64'(dcf_out), 64'(0));
        check("abort_sec", 64'(sec_cnt), 64'(0));
        check("abort_frame", 64'(frame), 64'(0));
        check("abort_done", 64'(frame_done), 64'(0));
        GSR = 1'b0;
        step();

        set_rand_fields();
        issue_start();
        wait_idle();

        repeat (4) step();
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
